beep_seq: RTL and testbench

BEEP_SEQ -- requirements
Module: beep_seq

---
 rtl/beep_seq.sv | 163 ++++++++++++++++
 tb/tb_beep_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/beep_seq.sv
// Two-tone buzzer sequencer: plays NUM_SEG segments that alternate between two latched tones.
// Define BEEP_SEQ_GAP_EN to insert a silent GAP_TICKS gap between segments.
module beep_seq #(
    parameter int SEG_TICKS = 250,
    parameter int NUM_SEG   = 4,
    parameter int DIV_W     = 8,
    parameter int GAP_TICKS = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] div_a,
    input  logic [DIV_W-1:0] div_b,
    output logic             beep,
    output logic             busy,
    output logic             over
);

    localparam int TICK_MAX = (SEG_TICKS > GAP_TICKS) ? SEG_TICKS : GAP_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);
    localparam int SEG_W    = $clog2(NUM_SEG + 1);
    localparam logic [TICK_W-1:0] SEG_LAST = TICK_W'(SEG_TICKS - 1);
    localparam logic [SEG_W-1:0]  LAST_SEG = SEG_W'(NUM_SEG - 1);
`ifdef BEEP_SEQ_GAP_EN
    localparam logic [TICK_W-1:0] GAP_LAST = TICK_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2,
        GAP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;
`endif

    state_t             state, state_n;
    logic [SEG_W-1:0]   seg, seg_n;
    logic [TICK_W-1:0]  tick, tick_n;
    logic [DIV_W-1:0]   tone_cnt, tone_n;
    logic [DIV_W-1:0]   lat_a, lat_a_n;
    logic [DIV_W-1:0]   lat_b, lat_b_n;
    logic [DIV_W-1:0]   div_cur;
    logic               beep_n, over_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            seg      <= '0;
            tick     <= '0;
            tone_cnt <= '0;
            lat_a    <= '0;
            lat_b    <= '0;
            beep     <= 1'b0;
            over     <= 1'b0;
        end else begin
            state    <= state_n;
            seg      <= seg_n;
            tick     <= tick_n;
            tone_cnt <= tone_n;
            lat_a    <= lat_a_n;
            lat_b    <= lat_b_n;
            beep     <= beep_n;
            over     <= over_n;
        end
    end

    // Even segments play tone A, odd segments tone B.
    assign div_cur = seg[0] ? lat_b : lat_a;

    always_comb begin
        state_n = state;
        seg_n   = seg;
        tick_n  = tick;
        tone_n  = tone_cnt;
        lat_a_n = lat_a;
        lat_b_n = lat_b;
        beep_n  = beep;
        over_n  = over;

        if (abort) begin
            state_n = IDLE;
            seg_n   = '0;
            tick_n  = '0;
            tone_n  = '0;
            beep_n  = 1'b0;
            over_n  = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_n = PLAY;
                        seg_n   = '0;
                        tick_n  = '0;
                        tone_n  = '0;
                        beep_n  = 1'b0;
                        over_n  = 1'b0;
                        lat_a_n = div_a;
                        lat_b_n = div_b;
                    end
                end
                PLAY: begin
                    if (div_cur == '0) begin
                        tone_n = '0;
                        beep_n = 1'b0;
                    end else if (tone_cnt == div_cur - DIV_W'(1)) begin
                        tone_n = '0;
                        beep_n = ~beep;
                    end else begin
                        tone_n = tone_cnt + DIV_W'(1);
                    end

                    // Segment boundary overrides the tone step: every segment starts silent.
                    if (tick == SEG_LAST) begin
                        tick_n = '0;
                        tone_n = '0;
                        beep_n = 1'b0;
                        if (seg == LAST_SEG) begin
                            state_n = DONE;
                            over_n  = 1'b1;
                        end else begin
                            seg_n = seg + SEG_W'(1);
`ifdef BEEP_SEQ_GAP_EN
                            state_n = GAP;
`endif
                        end
                    end else begin
                        tick_n = tick + TICK_W'(1);
                    end
                end
`ifdef BEEP_SEQ_GAP_EN
                GAP: begin
                    beep_n = 1'b0;
                    tone_n = '0;
                    if (tick == GAP_LAST) begin
                        tick_n  = '0;
                        state_n = PLAY;
                    end else begin
                        tick_n = tick + TICK_W'(1);
                    end
                end
`endif
                default: begin
                    state_n = IDLE;
                    beep_n  = 1'b0;
                    over_n  = 1'b0;
                end
            endcase
        end
    end

`ifdef BEEP_SEQ_GAP_EN
    assign busy = (state == PLAY) || (state == GAP);
`else
    assign busy = (state == PLAY);
`endif

endmodule

// File: tb/tb_beep_seq.sv
// Directed bench for beep_seq: expected {beep,busy,over} per cycle is queued at start and popped per cycle.
module tb_beep_seq;

    localparam int SEG  = 8;
    localparam int NSEG = 4;
    localparam int GAPT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] div_a = 8'd0;
    logic [7:0] div_b = 8'd0;
    logic       beep, busy, over;

    int tests = 0;
    int fails = 0;
    logic [2:0] sb[$];

    beep_seq #(
        .SEG_TICKS(SEG),
        .NUM_SEG  (NSEG),
        .DIV_W    (8),
        .GAP_TICKS(GAPT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .abort(abort),
        .div_a(div_a),
        .div_b(div_b),
        .beep (beep),
        .busy (busy),
        .over (over)
    );

    always #5 clk = ~clk;

    // Reference waveform: cycle c counted from the first cycle in PLAY.
    function automatic logic [2:0] exp_at(input int c, input int da, input int db);
        int period, total, s, p, d;
        logic b;
`ifdef BEEP_SEQ_GAP_EN
        period = SEG + GAPT;
        total  = NSEG * SEG + (NSEG - 1) * GAPT;
`else
        period = SEG;
        total  = NSEG * SEG;
`endif
        if (c >= total) return 3'b001;
        s = c / period;
        p = c % period;
        if (p >= SEG) return 3'b010;
        d = (s % 2 == 1) ? db : da;
        b = (d == 0) ? 1'b0 : (((p / d) % 2) == 1);
        return {b, 2'b10};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [2:0] exp);
        tests++;
        assert ({beep, busy, over} === exp) else begin
            fails++;
            $error("FAIL %s: {beep,busy,over} got %b expected %b", tag, {beep, busy, over}, exp);
        end
    endtask

    // kind: 0 plain, 1 extra start with new div_a at cycle 4, 2 abort at cut, 3 rst+start at cut
    task automatic run_seq(input string tag, input int da, input int db, input int n,
                           input int cut, input int kind);
        logic [2:0] e;
        div_a = 8'(da);
        div_b = 8'(db);
        start = 1'b1;
        for (int c = 0; c < n; c++)
            sb.push_back((cut >= 0 && c > cut) ? 3'b000 : exp_at(c, da, db));
        step();
        start = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL %s_sb_empty: got size 0 expected >0", tag);
            end else begin
                e = sb.pop_front();
                check($sformatf("%s_c%0d", tag, c), e);
            end
            if (kind == 1 && c == 4) begin start = 1'b1; div_a = 8'd3; end
            if (kind == 1 && c == 5) start = 1'b0;
            if (kind == 2 && c == cut) abort = 1'b1;
            if (kind == 2 && c == cut + 1) abort = 1'b0;
            if (kind == 3 && c == cut) begin rst = 1'b1; start = 1'b1; end
            if (kind == 3 && c == cut + 1) begin rst = 1'b0; start = 1'b0; end
            step();
        end
    endtask

    int len;

    initial begin
`ifdef BEEP_SEQ_GAP_EN
        len = NSEG * SEG + (NSEG - 1) * GAPT + 4;
`else
        len = NSEG * SEG + 4;
`endif
        rst = 1'b1;
        step();
        step();
        check("reset", 3'b000);
        rst = 1'b0;
        step();
        check("idle", 3'b000);

        run_seq("basic", 2, 4, len, -1, 0);
        check("done_hold", 3'b001);
        run_seq("restart_ignore", 2, 4, len, -1, 1);
        run_seq("silent_a", 0, 1, len, -1, 0);
        run_seq("abort", 2, 4, 20, 10, 2);

        abort = 1'b1;
        start = 1'b1;
        step();
        check("abort_wins", 3'b000);
        abort = 1'b0;
        start = 1'b0;
        step();
        check("abort_idle", 3'b000);

        run_seq("rst_mid", 3, 5, 20, 12, 3);
        check("rst_idle", 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
